// File: rtl/blockade_sound.sv
// Blockade sound generator: turns CPU OUT-port writes into an 8-bit mono
// sample made of a programmable square-wave tone plus an envelope-gated
// LFSR noise burst (the crash sound).
module blockade_sound #(
  parameter int TICK_DIV = 1000,
  parameter int ENV_DIV  = 256
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       outp,
  input  logic [3:0] port_addr,
  input  logic [7:0] port_data,
  output logic [7:0] audio,
  output logic       sound_active
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int EW = (ENV_DIV > 1) ? $clog2(ENV_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [EW-1:0] ENV_LAST  = EW'(ENV_DIV - 1);

  // Next LFSR state: shift left, feedback from taps 16,14,13,11.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    lfsr_next = {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  // Sample mix: tone contributes 0x40, noise contributes env/2; max 0xBF.
  function automatic logic [7:0] mix(input logic       ff,
                                     input logic       nb,
                                     input logic [7:0] env);
    logic [7:0] t;
    logic [7:0] n;
    t   = ff ? 8'h40 : 8'h00;
    n   = nb ? {1'b0, env[7:1]} : 8'h00;
    mix = t + n;
  endfunction

  logic [TW-1:0] tick_pre_q, tick_pre_d;
  logic          outp_last_q, outp_last_d;
  logic [7:0]    tone_div_q, tone_div_d;
  logic [7:0]    tone_cnt_q, tone_cnt_d;
  logic          tone_ff_q, tone_ff_d;
  logic [7:0]    env_q, env_d;
  logic [EW-1:0] env_pre_q, env_pre_d;
  logic [15:0]   lfsr_q, lfsr_d;
  logic [7:0]    audio_q, audio_d;
  logic          sound_active_q, sound_active_d;

  logic tick_s;
  logic wr_s;
  logic unused_addr_s;

  // Port 3 is decoded by the core but has no sound function.
  assign unused_addr_s = port_addr[3];

  assign audio        = audio_q;
  assign sound_active = sound_active_q;

  // Tick prescaler and write-event edge detection on the OUT strobe.
  always_comb begin
    tick_s      = (tick_pre_q == TICK_LAST);
    outp_last_d = outp;
    wr_s        = outp & ~outp_last_q;
    if (tick_s) begin
      tick_pre_d = '0;
    end else begin
      tick_pre_d = tick_pre_q + TW'(1);
    end
  end

  // Tone divider: a load from port 0 wins over a coincident tick.
  always_comb begin
    tone_div_d = tone_div_q;
    tone_cnt_d = tone_cnt_q;
    tone_ff_d  = tone_ff_q;
    if (wr_s && port_addr[0]) begin
      tone_div_d = port_data;
      tone_cnt_d = port_data;
    end else if (tone_div_q == 8'h00) begin
      tone_ff_d = 1'b0;
    end else if (tick_s) begin
      if (tone_cnt_q == 8'hFF) begin
        tone_cnt_d = tone_div_q;
        tone_ff_d  = ~tone_ff_q;
      end else begin
        tone_cnt_d = tone_cnt_q + 8'h01;
      end
    end else begin
      tone_cnt_d = tone_cnt_q;
    end
  end

  // Envelope: start/stop writes win over a coincident tick; stop beats start.
  always_comb begin
    env_d     = env_q;
    env_pre_d = env_pre_q;
    if (wr_s && (port_addr[1] || port_addr[2])) begin
      if (port_addr[2]) begin
        env_d = 8'h00;
      end else begin
        env_d = 8'hFF;
      end
      if (port_addr[1]) begin
        env_pre_d = '0;
      end else begin
        env_pre_d = env_pre_q;
      end
    end else if (tick_s && (env_q != 8'h00)) begin
      if (env_pre_q == ENV_LAST) begin
        env_pre_d = '0;
        env_d     = env_q - 8'h01;
      end else begin
        env_pre_d = env_pre_q + EW'(1);
      end
    end else begin
      env_d = env_q;
    end
  end

  // Noise source and registered output mix.
  always_comb begin
    if (tick_s) begin
      lfsr_d = lfsr_next(lfsr_q);
    end else begin
      lfsr_d = lfsr_q;
    end
    audio_d        = mix(tone_ff_q, lfsr_q[0], env_q);
    sound_active_d = (tone_div_q != 8'h00) | (env_q != 8'h00);
  end

  // State register with asynchronous active-high reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_pre_q     <= '0;
      outp_last_q    <= 1'b0;
      tone_div_q     <= 8'h00;
      tone_cnt_q     <= 8'h00;
      tone_ff_q      <= 1'b0;
      env_q          <= 8'h00;
      env_pre_q      <= '0;
      lfsr_q         <= 16'h0001;
      audio_q        <= 8'h00;
      sound_active_q <= 1'b0;
    end else begin
      tick_pre_q     <= tick_pre_d;
      outp_last_q    <= outp_last_d;
      tone_div_q     <= tone_div_d;
      tone_cnt_q     <= tone_cnt_d;
      tone_ff_q      <= tone_ff_d;
      env_q          <= env_d;
      env_pre_q      <= env_pre_d;
      lfsr_q         <= lfsr_d;
      audio_q        <= audio_d;
      sound_active_q <= sound_active_d;
    end
  end

endmodule

// File: tb/tb_blockade_sound.sv
// Directed bench for blockade_sound, run with a short tick (4 clk) and a
// short envelope step (2 ticks) so full bursts fit in a few thousand cycles.
module tb_blockade_sound;

  logic       clk;
  logic       reset;
  logic       outp;
  logic [3:0] port_addr;
  logic [7:0] port_data;
  logic [7:0] audio;
  logic       sound_active;

  int total;
  int bad;
  int cyc;

  blockade_sound #(.TICK_DIV(4), .ENV_DIV(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .outp         (outp),
    .port_addr    (port_addr),
    .port_data    (port_data),
    .audio        (audio),
    .sound_active (sound_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock edge; sample 1 ns after it. cyc counts edges since reset release.
  task automatic step();
    @(posedge clk);
    #1;
    cyc = cyc + 1;
  endtask

  // Single-edge OUT write, strobe dropped right after the write edge.
  task automatic write_pulse(input logic [3:0] a, input logic [7:0] d);
    port_addr = a;
    port_data = d;
    outp      = 1'b1;
    step();
    outp      = 1'b0;
    port_addr = 4'h0;
    port_data = 8'h00;
  endtask

  task automatic test_reset();
    int errs;
    errs = 0;
    reset = 1'b1; outp = 1'b0; port_addr = 4'h0; port_data = 8'h00;
    repeat (3) step();
    total++; if (audio !== 8'h00) begin bad++; $display("FAIL reset_audio got=%h want=00", audio); end
    total++; if (sound_active !== 1'b0) begin bad++; $display("FAIL reset_active got=%b want=0", sound_active); end
    total++; if (dut.lfsr_q !== 16'h0001) begin bad++; $display("FAIL reset_lfsr got=%h want=0001", dut.lfsr_q); end
    reset = 1'b0;
    cyc = 0;
    for (int n = 1; n <= 5000; n++) begin
      step();
      if (audio !== 8'h00 || sound_active !== 1'b0) errs++;
      if (n == 1) begin
        total++; if (dut.lfsr_q !== 16'h0001) begin bad++; $display("FAIL lfsr_e1 got=%h want=0001", dut.lfsr_q); end
      end
      if (n == 4) begin
        total++; if (dut.lfsr_q !== 16'h0002) begin bad++; $display("FAIL lfsr_e4 got=%h want=0002", dut.lfsr_q); end
      end
      if (n == 40) begin
        total++; if (dut.lfsr_q !== 16'h0400) begin bad++; $display("FAIL lfsr_e40 got=%h want=0400", dut.lfsr_q); end
      end
      if (n == 44) begin
        total++; if (dut.lfsr_q !== 16'h0801) begin bad++; $display("FAIL lfsr_e44 got=%h want=0801", dut.lfsr_q); end
      end
    end
    total++; if (errs !== 0) begin bad++; $display("FAIL idle_quiet bad_cycles=%0d want=0", errs); end
  endtask

  task automatic test_tone();
    logic prev;
    logic ff_exp;
    int   n;
    bit   found;
    write_pulse(4'b0001, 8'hFE);
    total++; if (dut.tone_div_q !== 8'hFE) begin bad++; $display("FAIL tone_div got=%h want=FE", dut.tone_div_q); end
    total++; if (dut.tone_cnt_q !== 8'hFE) begin bad++; $display("FAIL tone_cnt got=%h want=FE", dut.tone_cnt_q); end
    step();
    total++; if (sound_active !== 1'b1) begin bad++; $display("FAIL tone_active got=%b want=1", sound_active); end
    ff_exp = 1'b0;
    prev   = dut.tone_ff_q;
    found  = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (dut.tone_ff_q !== prev) found = 1'b1;
    end
    total++; if (found !== 1'b1) begin bad++; $display("FAIL tone_first_toggle got=none want=within 20 clk"); end
    ff_exp = 1'b1;
    total++; if (dut.tone_ff_q !== ff_exp) begin bad++; $display("FAIL tone_ff_first got=%b want=%b", dut.tone_ff_q, ff_exp); end
    for (int k = 0; k < 2; k++) begin
      step();
      total++; if (audio !== (ff_exp ? 8'h40 : 8'h00)) begin bad++; $display("FAIL tone_audio%0d got=%h want=%h", k, audio, ff_exp ? 8'h40 : 8'h00); end
      prev = dut.tone_ff_q;
      n = 1;
      while (dut.tone_ff_q === prev && n < 30) begin
        step();
        n++;
      end
      ff_exp = ~ff_exp;
      total++; if (n !== 8) begin bad++; $display("FAIL tone_halfperiod%0d got=%0d want=8", k, n); end
    end
  endtask

  task automatic test_hold();
    port_addr = 4'b0001; port_data = 8'h10; outp = 1'b1;
    step();
    total++; if (dut.tone_cnt_q !== 8'h10) begin bad++; $display("FAIL hold_load got=%h want=10", dut.tone_cnt_q); end
    repeat (19) step();
    total++; if (dut.tone_cnt_q < 8'h14 || dut.tone_cnt_q > 8'h15) begin bad++; $display("FAIL hold_single_load got=%h want=14..15", dut.tone_cnt_q); end
    outp = 1'b0; port_addr = 4'h0; port_data = 8'h00;
    step();
    write_pulse(4'b0001, 8'h00);
    total++; if (dut.tone_div_q !== 8'h00) begin bad++; $display("FAIL off_div got=%h want=00", dut.tone_div_q); end
    step();
    total++; if (dut.tone_ff_q !== 1'b0) begin bad++; $display("FAIL off_ff got=%b want=0", dut.tone_ff_q); end
    repeat (20) step();
    total++; if (dut.tone_cnt_q !== 8'h00) begin bad++; $display("FAIL off_cnt_frozen got=%h want=00", dut.tone_cnt_q); end
    total++; if (sound_active !== 1'b0) begin bad++; $display("FAIL off_active got=%b want=0", sound_active); end
    total++; if (audio !== 8'h00) begin bad++; $display("FAIL off_audio got=%h want=00", audio); end
  endtask

  task automatic test_env();
    int n, fe_at, fd_at, errs;
    logic [7:0] mx;
    logic sa_mid;
    n = 0; fe_at = -1; fd_at = -1; errs = 0; mx = 8'h00; sa_mid = 1'b0;
    port_addr = 4'b0010; outp = 1'b1;
    step();
    outp = 1'b0; port_addr = 4'h0;
    total++; if (dut.env_q !== 8'hFF) begin bad++; $display("FAIL env_start got=%h want=FF", dut.env_q); end
    total++; if (dut.env_pre_q !== 1'b0) begin bad++; $display("FAIL env_pre_start got=%h want=0", dut.env_pre_q); end
    while (dut.env_q !== 8'h00 && n < 2100) begin
      step();
      n++;
      if (audio > 8'h7F) errs++;
      if (audio > mx) mx = audio;
      if (dut.env_q === 8'hFE && fe_at < 0) fe_at = n;
      if (dut.env_q === 8'hFD && fd_at < 0) fd_at = n;
      if (n == 1000) sa_mid = sound_active;
    end
    total++; if (fe_at < 5 || fe_at > 8) begin bad++; $display("FAIL env_first_step got=%0d want=5..8", fe_at); end
    total++; if (fd_at - fe_at !== 8) begin bad++; $display("FAIL env_step_period got=%0d want=8", fd_at - fe_at); end
    total++; if (n < 2037 || n > 2040) begin bad++; $display("FAIL env_duration got=%0d want=2037..2040", n); end
    total++; if (errs !== 0) begin bad++; $display("FAIL env_audio_cap over=%0d want=0", errs); end
    total++; if (mx === 8'h00) begin bad++; $display("FAIL env_noise_heard got=%h want=nonzero", mx); end
    total++; if (sa_mid !== 1'b1) begin bad++; $display("FAIL env_active_mid got=%b want=1", sa_mid); end
    step();
    total++; if (sound_active !== 1'b0) begin bad++; $display("FAIL env_active_end got=%b want=0", sound_active); end
    total++; if (audio !== 8'h00) begin bad++; $display("FAIL env_audio_end got=%h want=00", audio); end
  endtask

  task automatic test_stop_start();
    write_pulse(4'b0010, 8'h00);
    repeat (3) step();
    write_pulse(4'b0110, 8'h00);
    total++; if (dut.env_q !== 8'h00) begin bad++; $display("FAIL stop_beats_start got=%h want=00", dut.env_q); end
    step();
    while ((cyc + 1) % 4 != 0) step();
    port_addr = 4'b0010; outp = 1'b1;
    step();
    outp = 1'b0; port_addr = 4'h0;
    repeat (4) step();
    total++; if (dut.env_pre_q !== 1'b1 || dut.env_q !== 8'hFF) begin bad++; $display("FAIL pre_setup got=%h/%h want=FF/1", dut.env_q, dut.env_pre_q); end
    repeat (3) step();
    port_addr = 4'b0010; outp = 1'b1;
    step();
    outp = 1'b0; port_addr = 4'h0;
    total++; if (dut.env_q !== 8'hFF) begin bad++; $display("FAIL start_vs_tick_env got=%h want=FF", dut.env_q); end
    total++; if (dut.env_pre_q !== 1'b0) begin bad++; $display("FAIL start_vs_tick_pre got=%h want=0", dut.env_pre_q); end
    step();
  endtask

  task automatic test_reset_mid();
    int n;
    write_pulse(4'b0001, 8'hFE);
    step();
    write_pulse(4'b0010, 8'h00);
    n = 0;
    while (dut.env_q !== 8'h80 && n < 1200) begin
      step();
      n++;
    end
    total++; if (dut.env_q !== 8'h80) begin bad++; $display("FAIL mid_reach80 got=%h want=80", dut.env_q); end
    total++; if (sound_active !== 1'b1) begin bad++; $display("FAIL mid_active got=%b want=1", sound_active); end
    reset = 1'b1;
    #1;
    total++; if (audio !== 8'h00) begin bad++; $display("FAIL mid_rst_audio got=%h want=00", audio); end
    total++; if (sound_active !== 1'b0) begin bad++; $display("FAIL mid_rst_active got=%b want=0", sound_active); end
    total++; if (dut.env_q !== 8'h00 || dut.tone_div_q !== 8'h00 || dut.tone_ff_q !== 1'b0) begin bad++; $display("FAIL mid_rst_state got=%h/%h/%b want=00/00/0", dut.env_q, dut.tone_div_q, dut.tone_ff_q); end
    total++; if (dut.lfsr_q !== 16'h0001) begin bad++; $display("FAIL mid_rst_lfsr got=%h want=0001", dut.lfsr_q); end
    step();
    reset = 1'b0;
    cyc = 0;
    step();
    total++; if (audio !== 8'h00) begin bad++; $display("FAIL post_rst_audio got=%h want=00", audio); end
    total++; if (dut.lfsr_q !== 16'h0001) begin bad++; $display("FAIL post_rst_lfsr got=%h want=0001", dut.lfsr_q); end
    total++; if (sound_active !== 1'b0) begin bad++; $display("FAIL post_rst_active got=%b want=0", sound_active); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    cyc   = 0;
    reset = 1'b1;
    outp  = 1'b0;
    port_addr = 4'h0;
    port_data = 8'h00;
    test_reset();
    test_tone();
    test_hold();
    test_env();
    test_stop_start();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
